// File: rtl/seq_detect_pkg.sv
// Shared constants and types for the programmable serial sequence detector.
package seq_detect_pkg;

    localparam int DFLT_PAT_W = 8;
    localparam int DFLT_LEN_W = $clog2(DFLT_PAT_W + 1);
    localparam logic [DFLT_PAT_W-1:0] DFLT_PATTERN = 8'b0000_1010;
    localparam int DFLT_LEN = 4;
    localparam int DFLT_CNT_W = 16;

    // How history is treated after a match.
    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    // Width needed to hold a length of 0..pat_w.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    function automatic ovl_mode_e ovl_mode(input int overlap);
        return (overlap != 0) ? OVL_ON : OVL_OFF;
    endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Shift-window advance and masked length compare for seq_detect_prog.
// Purely combinational: the caller decides whether the bit is accepted.
module seq_window_cmp
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DFLT_PAT_W,
    parameter int LEN_W = DFLT_LEN_W
) (
    input  logic [PAT_W-1:0] window,
    input  logic [LEN_W-1:0] hist,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             in_bit,
    output logic [PAT_W-1:0] next_window,
    output logic [LEN_W-1:0] next_hist,
    output logic             match
);

    logic [PAT_W-1:0] mask;

    // Select the low len bits; pattern bits above len-1 never take part.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // Shift the new bit in at the LSB and compare against the programmed pattern.
    always_comb begin
        next_window = {window[PAT_W-2:0], in_bit};
        next_hist   = (hist >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : hist + LEN_W'(1);
        match       = (next_hist >= len) && (((next_window ^ pattern) & mask) == '0);
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector (Moore, registered detect).
// Optional match counter enabled by defining SEQ_DETECT_CNT_EN; without it
// match_cnt is tied to zero and no counter is built.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int                  PAT_W       = DFLT_PAT_W,
    parameter logic [PAT_W-1:0]    DEF_PATTERN = PAT_W'(DFLT_PATTERN),
    parameter int                  DEF_LEN     = DFLT_LEN,
    parameter int                  OVERLAP     = 1,
    parameter int                  CNT_W       = DFLT_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         in_bit,
    input  logic                         cfg_we,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    output logic                         detect,
    output logic                         cfg_err,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int        LEN_W    = len_width(PAT_W);
    localparam ovl_mode_e OVL_MODE = ovl_mode(OVERLAP);

    logic [PAT_W-1:0] pattern, pattern_d;
    logic [LEN_W-1:0] len, len_d;
    logic [PAT_W-1:0] window, window_d;
    logic [LEN_W-1:0] hist, hist_d, hist_clean;
    logic             detect_d, cfg_err_d;

    logic [PAT_W-1:0] nxt_window;
    logic [LEN_W-1:0] nxt_hist;
    logic             match;
    logic             hist_bad;
    logic             cfg_ok;

    assign hist_bad   = (hist > LEN_W'(PAT_W));
    assign hist_clean = hist_bad ? '0 : hist;
    assign cfg_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

    seq_window_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .window      (window),
        .hist        (hist_clean),
        .pattern     (pattern),
        .len         (len),
        .in_bit      (in_bit),
        .next_window (nxt_window),
        .next_hist   (nxt_hist),
        .match       (match)
    );

    // Next-state: a config write takes priority and swallows that cycle's bit.
    always_comb begin
        pattern_d = pattern;
        len_d     = len;
        window_d  = window;
        hist_d    = hist_clean;
        detect_d  = 1'b0;
        cfg_err_d = 1'b0;
        if (cfg_we) begin
            if (cfg_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                window_d  = '0;
                hist_d    = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (in_valid) begin
            window_d = nxt_window;
            hist_d   = nxt_hist;
            detect_d = match;
            if (match && (OVL_MODE == OVL_OFF)) begin
                hist_d = '0;
            end
        end
        // An out-of-range history count is never trusted.
        if (hist_bad) begin
            hist_d = '0;
        end
    end

    // Configuration, window and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= DEF_PATTERN;
            len     <= LEN_W'(DEF_LEN);
            window  <= '0;
            hist    <= '0;
            detect  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            pattern <= pattern_d;
            len     <= len_d;
            window  <= window_d;
            hist    <= hist_d;
            detect  <= detect_d;
            cfg_err <= cfg_err_d;
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating count of detect pulses; config writes leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (detect_d && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_cnt = cnt;
`else
    assign match_cnt = '0;
`endif

endmodule
